// File: rtl/onehot_enc_pkg.sv
// Shared types and constants for the one-hot encoder skid buffer.
package onehot_enc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int ERR_CNT_MAX = 255;

endpackage

// File: rtl/onehot_enc_core.sv
// Combinational priority encoder: lowest set bit wins, err flags any non-one-hot vector.
module onehot_enc_core #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             err
);

  // Scanning from the top down lets the lowest set bit overwrite the result last.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDXW'(i);
    end
    err = ($countones(vec) != 1);
  end

endmodule

// File: rtl/onehot_enc.sv
// One-hot to binary encoder behind a 2-entry skid buffer, with a saturating error counter.
// state | meaning
// EMPTY | no entry held, out_valid low
// ONE   | head entry valid
// FULL  | head and tail valid, in_ready low
module onehot_enc
  import onehot_enc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_vec,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  state_e          state_q, state_d;
  logic            in_ready_q, out_valid_q;
  logic [IDXW-1:0] head_idx_q, tail_idx_q;
  logic            head_err_q, tail_err_q;
  logic [7:0]      err_cnt_q;
  logic [IDXW-1:0] enc_idx;
  logic            enc_err;
  logic            accept, pop;

  onehot_enc_core #(.WIDTH(WIDTH), .IDXW(IDXW)) u_core (
    .vec (in_vec),
    .idx (enc_idx),
    .err (enc_err)
  );

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = FULL;
        else if (pop && !accept) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state so they never see out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_idx_q  <= '0;
      head_err_q  <= 1'b0;
      tail_idx_q  <= '0;
      tail_err_q  <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_idx_q <= enc_idx;
            head_err_q <= enc_err;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_idx_q <= enc_idx;
            head_err_q <= enc_err;
          end else if (accept) begin
            tail_idx_q <= enc_idx;
            tail_err_q <= enc_err;
          end
        end
        FULL: begin
          if (pop) begin
            head_idx_q <= tail_idx_q;
            head_err_q <= tail_err_q;
          end
        end
        default: ;
      endcase
      if (accept && enc_err && (err_cnt_q != 8'(ERR_CNT_MAX))) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_idx   = head_idx_q;
  assign out_err   = head_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/onehot_enc.md
ONEHOT_ENC -- requirements
Module: onehot_enc

Interface
REQ-001 Parameter WIDTH, default 4, number of one-hot input lines (SHALL be >= 2).
REQ-002 Parameter IDXW, default $clog2(WIDTH), index width, derived and not overridden.
REQ-003 clk  input  1  the single clock for all state; every flop updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  producer presents in_vec this cycle.
REQ-006 in_vec  input  WIDTH  one-hot grant/select vector to encode.
REQ-007 in_ready  output  1  block accepts in_vec this cycle.
REQ-008 out_valid  output  1  out_idx/out_err hold a valid entry.
REQ-009 out_ready  input  1  consumer takes the output entry this cycle.
REQ-010 out_idx  output  IDXW  binary index of the encoded bit.
REQ-011 out_err  output  1  the entry came from a vector that was not exactly one-hot.
REQ-012 err_cnt  output  8  saturating count of accepted erroneous vectors.

Function
REQ-013 Accept: in_valid & in_ready in a cycle SHALL accept in_vec.
REQ-014 Pop: out_valid & out_ready in a cycle SHALL pop the head entry.
REQ-015 Encode: out_idx SHALL be the index of the lowest set bit of in_vec, so bit 0 has the highest priority.
REQ-016 out_err SHALL be 1 iff popcount(in_vec) != 1.
REQ-017 An all-zero in_vec SHALL produce out_idx 0 and out_err 1.
REQ-018 Latency: an entry accepted at edge N SHALL appear on out_valid/out_idx/out_err immediately after edge N, with no combinational path from in_* to out_*.
REQ-019 Buffering: the block SHALL be a 2-entry skid buffer, FIFO order, with state EMPTY, ONE or FULL.
REQ-020 in_ready SHALL be 1 iff state != FULL and SHALL be decoded from state only, never from out_ready.
REQ-021 out_valid SHALL be 1 iff state != EMPTY.
REQ-022 State transitions:
- EMPTY + accept -> ONE.
- ONE + accept, no pop -> FULL.
- ONE + pop, no accept -> EMPTY.
- ONE + accept + pop -> ONE, head replaced by the new entry.
- FULL + pop -> ONE, second entry becomes head.
- All other cases hold state.
REQ-023 While out_valid=1 and out_ready=0, out_idx and out_err SHALL remain stable.
REQ-024 err_cnt SHALL increment by 1 on each accepted vector with out_err=1.
REQ-025 err_cnt SHALL saturate at 255, counting at accept time rather than pop time.
REQ-026 in_vec SHALL be ignored whenever in_valid=0 or in_ready=0.

Reset
REQ-027 While rst=1, outputs SHALL be: state EMPTY, out_valid 0, in_ready 0, out_idx 0, out_err 0, err_cnt 0.
REQ-028 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-029 Reset asserted mid-operation SHALL discard buffered entries immediately, without waiting for a clock edge.

Structure
REQ-030 Package onehot_enc_pkg SHALL hold the state enum (EMPTY, ONE, FULL) and the ERR_CNT_MAX=255 constant.
REQ-031 Encoding SHALL be a combinational sub-module onehot_enc_core (in: vec; out: idx, err), instantiated once, at the accept path.
REQ-032 Storage SHALL be two {idx, err} registers plus the state register.

Verification
REQ-033 Reset then a single accept (WIDTH=4, in_vec=4'b0100, out_ready=1) -> next cycle out_valid=1, out_idx=2, out_err=0; then EMPTY.
REQ-034 Error encodes: in_vec=4'b0110 -> idx 1, err 1; in_vec=4'b0000 -> idx 0, err 1; err_cnt=2.
REQ-035 Backpressure: out_ready=0, push 4'b0001 then 4'b1000 -> in_ready=0 (FULL), out_idx stays 0; raise out_ready -> pops give 0 then 3.
REQ-036 Simultaneous push and pop in ONE, streaming 4'b0001, 4'b0010, 4'b0100 with out_ready=1 -> out_idx 0, 1, 2 on consecutive cycles, and state never reaches FULL.
REQ-037 Saturation: 260 accepted zero vectors -> err_cnt=255 and held there.
REQ-038 Async reset while FULL, asserted between clock edges -> out_valid=0 and err_cnt=0 immediately, before the next edge.
